cluster_unpacker: RTL and testbench
===================================

# cluster_unpacker

Decodes the 8-cluster frames produced by the GEM cluster packer back into a flat 1536-strip S-bit hit map (24 VFATs × 64 strips). It sits on the receive side of the trigger link, or in the packer's verification loopback, on the clock4x domain. It expands two clusters per cycle, so it sustains one frame per 4 clocks (one frame per bunch crossing). It also reports per-frame cluster count, overflow, and a count of malformed addresses.

## Interface

Parameters:
- `NUM_CLUSTERS`, default 8: clusters per frame.
- `CLUSTERS_PER_BEAT`, default 2: clusters expanded per clock.
- `NUM_STRIPS`, default 1536: 24 VFATs × 64 strips.
- `ERR_CNT_W`, default 16: width of the error counter.

Ports:
- `clock4x` in 1: sole clock, rising edge.
- `global_reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: frame present on `cluster0..7`.
- `in_ready` out 1: frame accepted on an edge where `in_valid && in_ready`.
- `cluster0`..`cluster7` in 14 each: packed cluster.
  - `[10:0]` is the strip address.
  - `[13:11]` is the size, meaning extra strips.
- `overflow_in` in 1: packer overflow flag for this frame.
- `sbits` out 1536: decoded hit map; bit `n` is VFAT `n/64`, strip `n%64`.
- `out_valid` out 1: one-cycle strobe; new `sbits`, `cluster_count` and `overflow_out` are valid.
- `cluster_count` out 4: number of valid clusters in the frame (0–8).
- `overflow_out` out 1: latched `overflow_in` of the delivered frame.
- `addr_err_cnt` out `ERR_CNT_W`: saturating count of malformed addresses.
- `vfat2_sbits` out 192: present only with the configuration macro.

## Operation

Cluster decode:
- Address 0x7FF means no cluster; it contributes nothing and is not counted.
- Address 0–1535 is valid. Set strips `addr` through `addr+size` inclusive, 1 to 8 strips.
- The flat index may cross VFAT boundaries.
- Strips above 1535 are silently dropped.
- Address 1536–2046 is malformed.
  - It contributes no strips and is not counted in `cluster_count`.
  - It increments `addr_err_cnt` by 1 per malformed cluster, saturating at all-ones.
  - Two malformed clusters in one beat add 2.

State machine:
- IDLE (`in_ready=1`).
  - On accept: latch all clusters and `overflow_in`, clear the accumulator and count, then go to EXPAND with beat 0.
- EXPAND (beats 0–3).
  - Each cycle ORs the masks of clusters `2b` and `2b+1` into the accumulator and adds their valid count.
  - `in_ready=1` only in beat 3.
  - At the end of beat 3:
    - Load `sbits` with accumulator OR the final pair's masks.
    - Load `cluster_count` and `overflow_out`.
    - Pulse `out_valid`.
  - If a frame is accepted in beat 3, go to EXPAND beat 0 with the new frame; otherwise go to IDLE.

Behaviour at boundaries:
- Overlapping clusters OR together; count is still per cluster.
- `sbits`, `cluster_count` and `overflow_out` hold between strobes.
- `in_valid` while `in_ready=0` is ignored. The frame is not captured, and the source must hold it.

## Timing

- Accept at edge E0; `out_valid` is high during the cycle after edge E0+4. Latency is 4 clocks.
- Back-to-back frames accepted every 4 edges give `out_valid` every 4th cycle, with no gaps.
- `in_ready` is combinational from state and beat.
- Reset values:
  - all outputs 0, except `in_ready=1`;
  - state IDLE, beat 0;
  - `addr_err_cnt` 0.
- Reset asserted mid-frame aborts the frame: no `out_valid`, and outputs clear asynchronously.

## Configuration

- `CLUSTER_UNPACKER_VFAT2_EN` defined: `vfat2_sbits` exists.
  - Bit `k` is the OR of `sbits[8k+7:8k]`, giving 24 VFATs × 8 VFAT2-granularity S-bits.
  - It is registered together with `sbits` and is valid on the same `out_valid`.
  - Its reset value is 0.
- Macro undefined: the port and its logic are absent. All other behaviour is identical.

## Structure

Package `cluster_pkg` holds:
- constants `NUM_VFATS=24`, `STRIPS_PER_VFAT=64`, `ADDR_W=11`, `SIZE_W=3`, `CLUSTER_W=14`, `ADDR_INVALID=11'h7FF`, `ADDR_MAX=1535`;
- typedef `cluster_t` with fields addr and size;
- function `is_valid_addr`.

Sub-module `cluster_expander` is combinational:
- inputs: one `cluster_t`;
- outputs: a 1536-bit mask, a valid flag and a malformed flag;
- instantiated `CLUSTERS_PER_BEAT` times.

## Test plan

1. Reset, then a single frame with `cluster0` = addr 0, size 0 and the others 0x7FF → after 4 clocks, `out_valid` pulses, `sbits`=1 (bit 0 only), `cluster_count`=1.
2. `cluster3` = addr 60, size 7 → bits 60–67 set, spanning VFAT0 and VFAT1. With the macro defined, `vfat2_sbits` bits 7 and 8 are set.
3. addr 1533, size 7 → only bits 1533–1535 set. addr 1600 → no bits set, `cluster_count` excludes it, `addr_err_cnt` increments by 1.
4. Eight frames with `in_valid` held high → `in_ready` pattern 1,0,0,0 repeating; eight `out_valid` strobes spaced 4 cycles apart with correct per-frame maps. `overflow_in`=1 on frame 3 only → `overflow_out`=1 on strobe 3 only.
5. `global_reset` asserted at beat 2 → outputs go to 0 immediately, no `out_valid` follows, and the next frame decodes correctly.
6. Preload the counter near all-ones and send frames of eight malformed addresses → `addr_err_cnt` saturates at 0xFFFF and does not wrap.

Source files
------------

// File: rtl/cluster_pkg.sv
// Shared constants, cluster record and address helper for the GEM cluster unpacker.
package cluster_pkg;

    localparam int unsigned NUM_VFATS       = 24;
    localparam int unsigned STRIPS_PER_VFAT = 64;
    localparam int unsigned ADDR_W          = 11;
    localparam int unsigned SIZE_W          = 3;
    localparam int unsigned CLUSTER_W       = 14;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 11'h7FF;
    localparam logic [ADDR_W-1:0] ADDR_MAX     = 11'd1535;

    // Packed layout matches the link word: [13:11] size, [10:0] address.
    typedef struct packed {
        logic [SIZE_W-1:0] size;
        logic [ADDR_W-1:0] addr;
    } cluster_t;

    typedef enum logic {
        ST_IDLE,
        ST_EXPAND
    } state_t;

    function automatic logic is_valid_addr(input logic [ADDR_W-1:0] addr);
        return (addr <= ADDR_MAX);
    endfunction

endpackage

// File: rtl/cluster_expander.sv
// Combinational expansion of one packed cluster into a strip mask plus valid/malformed flags.
module cluster_expander
    import cluster_pkg::*;
#(
    parameter int unsigned NUM_STRIPS = 1536
) (
    input  cluster_t              cluster,
    output logic [NUM_STRIPS-1:0] mask,
    output logic                  valid,
    output logic                  malformed
);

    logic [NUM_STRIPS-1:0] run;

    // Build a run of size+1 ones at bit 0 and shift it to the address; bits past the top fall off.
    always_comb begin
        run = '0;
        for (int unsigned i = 0; i < (1 << SIZE_W); i++) begin
            run[i] = (i <= 32'(cluster.size));
        end
        valid     = (cluster.addr != ADDR_INVALID) && is_valid_addr(cluster.addr);
        malformed = (cluster.addr != ADDR_INVALID) && !is_valid_addr(cluster.addr);
        mask      = valid ? (run << cluster.addr) : '0;
    end

endmodule

// File: rtl/cluster_unpacker.sv
// Decodes 8-cluster frames into a flat 1536-strip hit map, two clusters per clock.
// Optional VFAT2-granularity output enabled by defining CLUSTER_UNPACKER_VFAT2_EN.
module cluster_unpacker
    import cluster_pkg::*;
#(
    parameter int unsigned NUM_CLUSTERS      = 8,
    parameter int unsigned CLUSTERS_PER_BEAT = 2,
    parameter int unsigned NUM_STRIPS        = 1536,
    parameter int unsigned ERR_CNT_W         = 16
) (
    input  logic                  clock4x,
    input  logic                  global_reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CLUSTER_W-1:0]  cluster0,
    input  logic [CLUSTER_W-1:0]  cluster1,
    input  logic [CLUSTER_W-1:0]  cluster2,
    input  logic [CLUSTER_W-1:0]  cluster3,
    input  logic [CLUSTER_W-1:0]  cluster4,
    input  logic [CLUSTER_W-1:0]  cluster5,
    input  logic [CLUSTER_W-1:0]  cluster6,
    input  logic [CLUSTER_W-1:0]  cluster7,
    input  logic                  overflow_in,
    output logic [NUM_STRIPS-1:0] sbits,
    output logic                  out_valid,
    output logic [3:0]            cluster_count,
    output logic                  overflow_out,
    output logic [ERR_CNT_W-1:0]  addr_err_cnt
`ifdef CLUSTER_UNPACKER_VFAT2_EN
    ,
    output logic [NUM_STRIPS/8-1:0] vfat2_sbits
`endif
);

    localparam int unsigned NUM_BEATS = NUM_CLUSTERS / CLUSTERS_PER_BEAT;
    localparam int unsigned BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int unsigned IDX_W     = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

    state_t                state, state_nxt;
    logic [BEAT_W-1:0]     beat, beat_nxt;
    logic                  accept, last_beat, busy;

    cluster_t              frame_in [8];
    cluster_t              latched  [NUM_CLUSTERS];
    logic                  ovf_q;
    logic [NUM_STRIPS-1:0] acc;
    logic [3:0]            cnt;

    cluster_t              sel  [CLUSTERS_PER_BEAT];
    logic [NUM_STRIPS-1:0] mask [CLUSTERS_PER_BEAT];
    logic [CLUSTERS_PER_BEAT-1:0] vld, bad;

    logic [NUM_STRIPS-1:0] beat_mask, frame_map;
    logic [3:0]            beat_cnt, frame_cnt;
    logic [ERR_CNT_W:0]    beat_err, err_sum;

    assign frame_in[0] = cluster_t'(cluster0);
    assign frame_in[1] = cluster_t'(cluster1);
    assign frame_in[2] = cluster_t'(cluster2);
    assign frame_in[3] = cluster_t'(cluster3);
    assign frame_in[4] = cluster_t'(cluster4);
    assign frame_in[5] = cluster_t'(cluster5);
    assign frame_in[6] = cluster_t'(cluster6);
    assign frame_in[7] = cluster_t'(cluster7);

    for (genvar j = 0; j < CLUSTERS_PER_BEAT; j++) begin : g_exp
        assign sel[j] = latched[IDX_W'(int'(beat) * CLUSTERS_PER_BEAT + j)];

        cluster_expander #(
            .NUM_STRIPS(NUM_STRIPS)
        ) u_exp (
            .cluster  (sel[j]),
            .mask     (mask[j]),
            .valid    (vld[j]),
            .malformed(bad[j])
        );
    end

    // State and beat register.
    always_ff @(posedge clock4x or posedge global_reset) begin
        if (global_reset) begin
            state <= ST_IDLE;
            beat  <= '0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
        end
    end

    // Next state: accepting always restarts at beat 0; the last beat falls back to IDLE otherwise.
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt = ST_EXPAND;
                    beat_nxt  = '0;
                end
            end
            ST_EXPAND: begin
                if (beat == LAST_BEAT) begin
                    state_nxt = in_valid ? ST_EXPAND : ST_IDLE;
                    beat_nxt  = '0;
                end else begin
                    beat_nxt = beat + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                beat_nxt  = '0;
            end
        endcase
    end

    // FSM outputs: ready in IDLE and on the final expand beat.
    always_comb begin
        busy      = (state == ST_EXPAND);
        last_beat = busy && (beat == LAST_BEAT);
        in_ready  = (state == ST_IDLE) || last_beat;
        accept    = in_valid && in_ready;
    end

    // Merge this beat's expanders and form the completed-frame and error-counter values.
    always_comb begin
        beat_mask = '0;
        beat_cnt  = '0;
        beat_err  = '0;
        for (int unsigned j = 0; j < CLUSTERS_PER_BEAT; j++) begin
            beat_mask = beat_mask | mask[j];
            beat_cnt  = beat_cnt + 4'(vld[j]);
            beat_err  = beat_err + (ERR_CNT_W+1)'(bad[j]);
        end
        frame_map = acc | beat_mask;
        frame_cnt = cnt + beat_cnt;
        err_sum   = {1'b0, addr_err_cnt} + beat_err;
    end

    // Datapath: accumulate per beat, publish on the last beat; a new accept overrides the accumulator.
    always_ff @(posedge clock4x or posedge global_reset) begin
        if (global_reset) begin
            for (int unsigned i = 0; i < NUM_CLUSTERS; i++) begin
                latched[i] <= '0;
            end
            ovf_q         <= 1'b0;
            acc           <= '0;
            cnt           <= '0;
            sbits         <= '0;
            cluster_count <= '0;
            overflow_out  <= 1'b0;
            out_valid     <= 1'b0;
            addr_err_cnt  <= '0;
        end else begin
            out_valid <= 1'b0;
            if (busy) begin
                acc          <= frame_map;
                cnt          <= frame_cnt;
                addr_err_cnt <= err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
            end
            if (last_beat) begin
                sbits         <= frame_map;
                cluster_count <= frame_cnt;
                overflow_out  <= ovf_q;
                out_valid     <= 1'b1;
            end
            if (accept) begin
                for (int unsigned i = 0; i < NUM_CLUSTERS; i++) begin
                    latched[i] <= frame_in[i];
                end
                ovf_q <= overflow_in;
                acc   <= '0;
                cnt   <= '0;
            end
        end
    end

`ifdef CLUSTER_UNPACKER_VFAT2_EN
    logic [NUM_STRIPS/8-1:0] frame_vfat2;

    // Fold each group of 8 strips into one VFAT2-granularity bit.
    always_comb begin
        frame_vfat2 = '0;
        for (int unsigned k = 0; k < NUM_STRIPS/8; k++) begin
            frame_vfat2[k] = |frame_map[8*k +: 8];
        end
    end

    // VFAT2 map is published alongside sbits.
    always_ff @(posedge clock4x or posedge global_reset) begin
        if (global_reset) begin
            vfat2_sbits <= '0;
        end else if (last_beat) begin
            vfat2_sbits <= frame_vfat2;
        end
    end
`endif

endmodule

// File: tb/tb_cluster_unpacker.sv
// Self-checking bench for cluster_unpacker against a frame-level reference model.
module tb_cluster_unpacker;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [13:0]   cl [8];
    logic          overflow_in;
    logic [1535:0] sbits;
    logic          out_valid;
    logic [3:0]    cluster_count;
    logic          overflow_out;
    logic [15:0]   addr_err_cnt;
`ifdef CLUSTER_UNPACKER_VFAT2_EN
    logic [191:0]  vfat2_sbits;
`endif

    int tests = 0;
    int fails = 0;
    int model_err = 0;

    cluster_unpacker dut (
        .clock4x      (clk),
        .global_reset (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .cluster0     (cl[0]),
        .cluster1     (cl[1]),
        .cluster2     (cl[2]),
        .cluster3     (cl[3]),
        .cluster4     (cl[4]),
        .cluster5     (cl[5]),
        .cluster6     (cl[6]),
        .cluster7     (cl[7]),
        .overflow_in  (overflow_in),
        .sbits        (sbits),
        .out_valid    (out_valid),
        .cluster_count(cluster_count),
        .overflow_out (overflow_out),
        .addr_err_cnt (addr_err_cnt)
`ifdef CLUSTER_UNPACKER_VFAT2_EN
        ,
        .vfat2_sbits  (vfat2_sbits)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_map(input string tag, input logic [1535:0] got, input logic [1535:0] exp);
        int d;
        int gc;
        int ec;
        d = -1; gc = 0; ec = 0;
        for (int i = 0; i < 1536; i++) begin
            if (d < 0 && got[i] !== exp[i]) d = i;
            if (got[i] === 1'b1) gc++;
            if (exp[i] === 1'b1) ec++;
        end
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: first differing bit %0d, got %0d bits set expected %0d bits set", tag, d, gc, ec);
        end
    endtask

    // Reference decode of one frame straight from the address/size rules.
    task automatic model_frame(input logic [13:0] f [8], output logic [1535:0] m, output int n, output int e);
        m = '0; n = 0; e = 0;
        for (int i = 0; i < 8; i++) begin
            int a;
            int s;
            a = int'(f[i][10:0]);
            s = int'(f[i][13:11]);
            if (a == 2047) continue;
            if (a > 1535) begin
                e++;
                continue;
            end
            n++;
            for (int k = 0; k <= s; k++) begin
                if (a + k < 1536) m[a + k] = 1'b1;
            end
        end
    endtask

    function automatic logic [191:0] fold(input logic [1535:0] m);
        logic [191:0] r;
        r = '0;
        for (int n = 0; n < 1536; n++) begin
            if (m[n]) r[n / 8] = 1'b1;
        end
        return r;
    endfunction

    task automatic add_err(input int e);
        model_err = (model_err + e > 65535) ? 65535 : model_err + e;
    endtask

    function automatic logic [13:0] rand_cluster();
        int r;
        logic [2:0] sz;
        logic [10:0] ad;
        r  = $urandom_range(0, 9);
        sz = 3'($urandom_range(0, 7));
        if (r < 3)       ad = 11'h7FF;
        else if (r == 3) ad = 11'($urandom_range(1536, 2046));
        else if (r == 4) ad = 11'($urandom_range(1528, 1535));
        else             ad = 11'($urandom_range(0, 1535));
        return {sz, ad};
    endfunction

    // Drive one isolated frame, then check latency, decode and the single-cycle strobe.
    task automatic single_frame(input string tag, input logic [13:0] f [8], input logic ovf);
        logic [1535:0] m;
        int n;
        int e;
        int lat;
        model_frame(f, m, n, e);
        for (int i = 0; i < 8; i++) cl[i] = f[i];
        overflow_in = ovf;
        in_valid = 1'b1;
        check({tag, "_ready"}, in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        overflow_in = 1'b0;
        add_err(e);
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, lat, 4);
        check_map({tag, "_sbits"}, sbits, m);
        check({tag, "_count"}, cluster_count, n);
        check({tag, "_ovf"}, overflow_out, ovf);
        check({tag, "_errcnt"}, addr_err_cnt, model_err);
`ifdef CLUSTER_UNPACKER_VFAT2_EN
        check_map({tag, "_vfat2"}, {1344'd0, vfat2_sbits}, {1344'd0, fold(m)});
`endif
        step();
        check({tag, "_strobe_drop"}, out_valid, 1'b0);
        check_map({tag, "_hold"}, sbits, m);
    endtask

    logic [13:0]   f [8];
    logic [13:0]   frames [8][8];
    logic [1535:0] emap [8];
    int            ecnt [8];
    int            eerr [8];

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        overflow_in = 1'b0;
        for (int i = 0; i < 8; i++) cl[i] = 14'h07FF;

        // Reset values
        step();
        step();
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check_map("rst_sbits", sbits, '0);
        check("rst_count", cluster_count, 0);
        check("rst_ovf", overflow_out, 1'b0);
        check("rst_errcnt", addr_err_cnt, 0);
        rst = 1'b0;
        step();

        // Single strip at address 0
        for (int i = 0; i < 8; i++) f[i] = 14'h07FF;
        f[0] = {3'd0, 11'd0};
        single_frame("t1", f, 1'b0);
        check_map("t1_bit0", sbits, 1536'd1);
        check("t1_one", cluster_count, 1);

        // Cluster crossing VFAT0/VFAT1
        for (int i = 0; i < 8; i++) f[i] = 14'h07FF;
        f[3] = {3'd7, 11'd60};
        single_frame("t2", f, 1'b0);
        check_map("t2_bits", sbits, {1536'd0, 8'hFF} << 60);
`ifdef CLUSTER_UNPACKER_VFAT2_EN
        check_map("t2_vfat2_direct", {1344'd0, vfat2_sbits}, 1536'h180);
`endif

        // Top-edge truncation plus malformed address
        for (int i = 0; i < 8; i++) f[i] = 14'h07FF;
        f[0] = {3'd7, 11'd1533};
        f[5] = {3'd0, 11'd1600};
        f[2] = {3'd2, 11'd100};
        single_frame("t3", f, 1'b0);
        check("t3_count", cluster_count, 2);
        check("t3_errcnt_one", addr_err_cnt, 1);

        // Eight back-to-back random frames with in_valid held high
        for (int fr = 0; fr < 8; fr++) begin
            for (int i = 0; i < 8; i++) begin
                f[i] = rand_cluster();
                frames[fr][i] = f[i];
            end
            model_frame(f, emap[fr], ecnt[fr], eerr[fr]);
            add_err(eerr[fr]);
        end
        begin
            int k;
            k = 0;
            for (int c = 0; c <= 40; c++) begin
                logic exp_ov;
                if (k < 8) begin
                    in_valid = 1'b1;
                    for (int i = 0; i < 8; i++) cl[i] = frames[k][i];
                    overflow_in = (k == 3);
                end else begin
                    in_valid = 1'b0;
                    overflow_in = 1'b0;
                end
                if (c <= 32) check($sformatf("t4_in_ready_c%0d", c), in_ready, (c % 4 == 0));
                exp_ov = (c >= 5) && ((c - 5) % 4 == 0) && ((c - 5) / 4 < 8);
                check($sformatf("t4_out_valid_c%0d", c), out_valid, exp_ov);
                if (exp_ov) begin
                    int fr;
                    fr = (c - 5) / 4;
                    check_map($sformatf("t4_sbits_f%0d", fr), sbits, emap[fr]);
                    check($sformatf("t4_count_f%0d", fr), cluster_count, ecnt[fr]);
                    check($sformatf("t4_ovf_f%0d", fr), overflow_out, (fr == 3));
`ifdef CLUSTER_UNPACKER_VFAT2_EN
                    check_map($sformatf("t4_vfat2_f%0d", fr), {1344'd0, vfat2_sbits}, {1344'd0, fold(emap[fr])});
`endif
                end
                step();
                if (c % 4 == 0 && k < 8) k++;
            end
        end
        check("t4_errcnt", addr_err_cnt, model_err);

        // Reset during beat 2 aborts the frame
        for (int i = 0; i < 8; i++) cl[i] = {3'd3, 11'($urandom_range(0, 1535))};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        model_err = 0;
        check("t5_out_valid", out_valid, 1'b0);
        check_map("t5_sbits", sbits, '0);
        check("t5_count", cluster_count, 0);
        check("t5_ovf", overflow_out, 1'b0);
        check("t5_errcnt", addr_err_cnt, 0);
        check("t5_in_ready", in_ready, 1'b1);
`ifdef CLUSTER_UNPACKER_VFAT2_EN
        check_map("t5_vfat2", {1344'd0, vfat2_sbits}, '0);
`endif
        step();
        rst = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 8; k++) begin
                step();
                if (out_valid) seen++;
            end
            check("t5_no_strobe", seen, 0);
        end
        for (int i = 0; i < 8; i++) f[i] = rand_cluster();
        f[1] = {3'd5, 11'd1000};
        single_frame("t5_after", f, 1'b1);

        // Error counter saturation
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        model_err = 0;
        in_valid = 1'b1;
        for (int fr = 0; fr < 8191; fr++) begin
            for (int i = 0; i < 8; i++) cl[i] = {3'($urandom_range(0, 7)), 11'($urandom_range(1536, 2046))};
            add_err(8);
            repeat (4) step();
        end
        in_valid = 1'b0;
        repeat (8) step();
        check("t6_near_full", addr_err_cnt, model_err);
        check("t6_near_full_abs", addr_err_cnt, 16'd65528);
        for (int i = 0; i < 8; i++) f[i] = {3'd1, 11'($urandom_range(1536, 2046))};
        single_frame("t6_a", f, 1'b0);
        single_frame("t6_b", f, 1'b0);
        check("t6_saturated", addr_err_cnt, 16'hFFFF);
        check("t6_count", cluster_count, 0);
        check_map("t6_sbits", sbits, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
